// File: rtl/int_pkg.sv
// Shared definitions for the priority interrupt controller: register
// offsets, FSM state encoding and the width of the interrupt number.
package int_pkg;

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_CUR  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  localparam int INTNUM_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_e;

endpackage

// File: rtl/int_if.sv
// Memory-mapped register window of the interrupt controller; the CPU side
// drives the strobes (master), the controller returns read data (slave).
interface int_if;
  logic        sel;
  logic        rd;
  logic        wr;
  logic [1:0]  reg_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, rd, wr, reg_addr, wdata, input rdata);
  modport slave  (input sel, rd, wr, reg_addr, wdata, output rdata);
endinterface

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for one asynchronous request line followed by a
// rising-edge detector producing a single-cycle pulse.
module int_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= src_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Priority interrupt controller: latches synchronised request edges as
// pending, masks them and presents the lowest-index request to the CPU.
module int_ctrl
  import int_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NSRC-1:0]     src,
  int_if.slave                bus,
  input  logic                int_ack,
  output logic                INTin,
  output logic [INTNUM_W-1:0] INTnum
);

  logic [NSRC-1:0]     edge_w;
  logic [NSRC-1:0]     pend_q, pend_d;
  logic [NSRC-1:0]     mask_q;
  logic [NSRC-1:0]     lockedOh;
  logic [NSRC-1:0]     w1cBits;
  logic [NSRC-1:0]     ackBits;
  logic [INTNUM_W-1:0] candNum;
  logic [INTNUM_W-1:0] intnum_q;
  logic [INTNUM_W-1:0] cur_q;
  logic                intin_q;
  logic                wrPend, wrMask, wrEoi, ackClr;
  logic                unusedWdata;
  state_e              state_q;

  for (genvar g = 0; g < NSRC; g++) begin : g_sync
    int_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .src_i   (src[g]),
      .pulse_o (edge_w[g])
    );
  end

  assign wrPend = bus.sel & bus.wr & (bus.reg_addr == REG_PEND);
  assign wrMask = bus.sel & bus.wr & (bus.reg_addr == REG_MASK);
  assign wrEoi  = bus.sel & bus.wr & (bus.reg_addr == REG_EOI);
  assign ackClr = (state_q == REQ) & int_ack;
  assign unusedWdata = ^bus.wdata[31:NSRC];

  // Scanning from the top down leaves the lowest enabled index in candNum.
  always_comb begin
    candNum  = '0;
    lockedOh = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend_q[i] & mask_q[i]) candNum = INTNUM_W'(i + 1);
    end
    for (int i = 0; i < NSRC; i++) begin
      lockedOh[i] = (intnum_q == INTNUM_W'(i + 1));
    end
  end

  // New edges are OR-ed in last so they survive a same-cycle W1C or ack clear.
  always_comb begin
    w1cBits = wrPend ? bus.wdata[NSRC-1:0] : '0;
    ackBits = ackClr ? lockedOh : '0;
    pend_d  = (pend_q & ~w1cBits & ~ackBits) | edge_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      mask_q   <= '1;
      cur_q    <= '0;
      intin_q  <= 1'b0;
      intnum_q <= '0;
      state_q  <= IDLE;
    end else begin
      pend_q <= pend_d;
      if (wrMask) mask_q <= bus.wdata[NSRC-1:0];
      case (state_q)
        IDLE: begin
          if (candNum != '0) begin
            state_q  <= REQ;
            intin_q  <= 1'b1;
            intnum_q <= candNum;
          end
        end
        REQ: begin
          if (int_ack) begin
            state_q  <= SERV;
            cur_q    <= intnum_q;
            intin_q  <= 1'b0;
            intnum_q <= '0;
          end
        end
        SERV: begin
          if (wrEoi) begin
            state_q <= IDLE;
            cur_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel && bus.rd) begin
      case (bus.reg_addr)
        REG_PEND: bus.rdata = 32'(pend_q);
        REG_MASK: bus.rdata = 32'(mask_q);
        REG_CUR:  bus.rdata = cur_q;
        default:  bus.rdata = '0;
      endcase
    end
  end

  assign INTin  = intin_q;
  assign INTnum = intnum_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scoreboard bench for int_ctrl: stimulus queues expected reads,
// interrupt presentations and pin states; a negedge monitor compares them.
module tb_int_ctrl;
  import int_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src;
  logic        int_ack;
  logic        INTin;
  logic [31:0] INTnum;

  int_if bus ();

  int_ctrl #(.NSRC(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .src     (src),
    .bus     (bus),
    .int_ack (int_ack),
    .INTin   (INTin),
    .INTnum  (INTnum)
  );

  always #5 clk = ~clk;

  logic [33:0] readQ[$];
  logic [31:0] intQ[$];
  logic [32:0] pinQ[$];
  logic        pinChk = 1'b0;
  logic        done = 1'b0;
  logic        prevIntin = 1'b0;
  int          timeouts = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic checkOutput(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every presented output consumes the oldest matching expectation.
  always @(negedge clk) begin
    logic [33:0] r;
    if (bus.sel && bus.rd) begin
      if (readQ.size() == 0) checkOutput("read_unexpected", 34'(bus.rdata), 34'h3_FFFF_FFFF);
      else begin
        r = readQ.pop_front();
        checkOutput($sformatf("read_reg%0d", r[33:32]), 34'(bus.rdata), 34'(r[31:0]));
      end
    end
    if (INTin && !prevIntin) begin
      if (intQ.size() == 0) checkOutput("int_unexpected", 34'(INTnum), 34'h3_FFFF_FFFF);
      else checkOutput("int_num", 34'(INTnum), 34'(intQ.pop_front()));
    end
    if (pinChk && pinQ.size() != 0) checkOutput("pins", 34'({INTin, INTnum}), 34'(pinQ.pop_front()));
    prevIntin = INTin;
    if (done) begin
      checkOutput("end_state", 34'(intQ.size() + readQ.size() + pinQ.size() + timeouts), 34'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [1:0] addr, input logic [31:0] exp);
    @(posedge clk); #1;
    readQ.push_back({addr, exp});
    bus.sel = 1'b1; bus.rd = 1'b1; bus.reg_addr = addr;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.rd = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.wr = 1'b1; bus.reg_addr = addr; bus.wdata = data;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic pinCheck(input logic expIn, input logic [31:0] expNum);
    pinQ.push_back({expIn, expNum});
    pinChk = 1'b1;
    @(negedge clk); #1;
    pinChk = 1'b0;
  endtask

  task automatic pulseSrc(input logic [3:0] bits, input int n);
    @(posedge clk); #1 src = bits;
    repeat (n) @(posedge clk);
    #1 src = 4'b0;
  endtask

  task automatic waitInt();
    int n = 0;
    while (!INTin && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!INTin) timeouts++;
    #1;
  endtask

  task automatic ack();
    @(posedge clk); #1 int_ack = 1'b1;
    @(posedge clk); #1 int_ack = 1'b0;
  endtask

  task automatic applyStimulus();
    // Reset values
    rst = 1'b1; src = '0; int_ack = 1'b0;
    bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.reg_addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    readReg(REG_PEND, 32'h0);
    readReg(REG_MASK, 32'hF);
    readReg(REG_CUR, 32'h0);
    readReg(REG_EOI, 32'h0);
    pinCheck(1'b0, 32'h0);

    // Single event with exact latency: INTin rises after edge 3
    intQ.push_back(32'd1);
    @(posedge clk); #1 src = 4'b0001;
    repeat (3) @(posedge clk);
    #1 pinCheck(1'b0, 32'h0);
    @(posedge clk); #1 pinCheck(1'b1, 32'd1);
    src = 4'b0;
    ack();
    pinCheck(1'b0, 32'h0);
    readReg(REG_CUR, 32'd1);
    readReg(REG_PEND, 32'h0);
    writeReg(REG_EOI, 32'hDEAD_BEEF);
    readReg(REG_CUR, 32'h0);

    // Priority: bits 2 and 1 together, source 1 wins
    intQ.push_back(32'd2);
    intQ.push_back(32'd3);
    pulseSrc(4'b0110, 3);
    waitInt();
    ack();
    readReg(REG_CUR, 32'd2);
    readReg(REG_PEND, 32'h4);
    writeReg(REG_EOI, 32'h0);
    waitInt();
    ack();
    readReg(REG_CUR, 32'd3);
    writeReg(REG_EOI, 32'h0);

    // Mask, including upper bits ignored
    writeReg(REG_MASK, 32'hFFFF_FFF0);
    readReg(REG_MASK, 32'h0);
    writeReg(REG_MASK, 32'hE);
    pulseSrc(4'b0001, 3);
    idle(6);
    pinCheck(1'b0, 32'h0);
    readReg(REG_PEND, 32'h1);
    intQ.push_back(32'd1);
    writeReg(REG_MASK, 32'hF);
    waitInt();
    // Masking and W1C of the locked source do not withdraw it
    writeReg(REG_MASK, 32'hE);
    writeReg(REG_PEND, 32'h1);
    pinCheck(1'b1, 32'd1);
    ack();
    readReg(REG_CUR, 32'd1);
    writeReg(REG_EOI, 32'h0);
    writeReg(REG_MASK, 32'hF);

    // Edge and W1C on the same bit in the same cycle: bit stays set
    writeReg(REG_MASK, 32'hD);
    pulseSrc(4'b0010, 3);
    idle(4);
    readReg(REG_PEND, 32'h2);
    @(posedge clk); #1 src = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.sel = 1'b1; bus.wr = 1'b1; bus.reg_addr = REG_PEND; bus.wdata = 32'h2;
    @(posedge clk); #1 bus.sel = 1'b0; bus.wr = 1'b0; src = 4'b0;
    readReg(REG_PEND, 32'h2);
    writeReg(REG_PEND, 32'h2);
    readReg(REG_PEND, 32'h0);
    writeReg(REG_MASK, 32'hF);

    // Edge on the ack cycle: source 1 re-presented after EOI
    intQ.push_back(32'd2);
    pulseSrc(4'b0010, 3);
    waitInt();
    idle(4);
    @(posedge clk); #1 src = 4'b0010;
    @(posedge clk); #1;
    @(posedge clk); #1 int_ack = 1'b1;
    @(posedge clk); #1 int_ack = 1'b0; src = 4'b0;
    pinCheck(1'b0, 32'h0);
    readReg(REG_CUR, 32'd2);
    readReg(REG_PEND, 32'h2);
    intQ.push_back(32'd2);
    writeReg(REG_EOI, 32'h0);
    waitInt();
    ack();
    writeReg(REG_EOI, 32'h0);
    readReg(REG_PEND, 32'h0);

    // Reset while in service drops everything
    intQ.push_back(32'd1);
    pulseSrc(4'b0001, 3);
    waitInt();
    ack();
    pulseSrc(4'b0100, 3);
    idle(2);
    readReg(REG_PEND, 32'h4);
    readReg(REG_CUR, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    readReg(REG_CUR, 32'h0);
    readReg(REG_PEND, 32'h0);
    readReg(REG_MASK, 32'hF);
    pinCheck(1'b0, 32'h0);
    idle(8);
  endtask

  initial begin
    applyStimulus();
    done = 1'b1;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Priority interrupt controller between the PC peripherals (tty keypress, UART, future timer) and the CPU's `INTin`/`INTnum` inputs. Synchronises and edge-detects up to NSRC request lines, latches them as pending, applies a software mask and presents the highest-priority request to the CPU with an ack/end-of-interrupt handshake. Memory-mapped at `Addr[31:28] == 4'hC`; the top level decodes the select and muxes `rdata` onto `BUS`.

## Interface
- `NSRC`, 4: number of request sources (1..8); source 0 has highest priority.
- `clk` in 1: CPU clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `src` in NSRC: raw request lines, any clock domain, active-high; each event held high ≥ 2 `clk` periods.
- `sel` in 1: register window selected (top-level decode of Addr[31:28]==4'hC).
- `rd` in 1: read strobe (Memread), qualified by `sel`.
- `wr` in 1: write strobe (Memwrite[0]), qualified by `sel`.
- `reg_addr` in 2: register index (Addr[3:2]).
- `wdata` in 32: write data from BUS.
- `rdata` out 32: read data; zero when not `sel && rd`.
- `int_ack` in 1: one-cycle CPU acknowledge of the presented interrupt.
- `INTin` out 1: interrupt request to CPU, registered.
- `INTnum` out 32: interrupt number = source index + 1, registered; 0 when idle.

## Operation
- Registers: 0 PEND (R; W1C on bits [NSRC-1:0]), 1 MASK (RW, 1 = enabled), 2 CUR (R; INTnum in service, 0 if none), 3 EOI (W any value ends service; reads 0). Bits above NSRC-1 read 0, writes ignored.
- Reset: PEND=0, MASK=all ones, CUR=0, `INTin`=0, `INTnum`=0, sync/edge flops=0, state IDLE.
- Per source: 2-flop synchroniser, then rising-edge detect; edge sets PEND bit.
- Candidate = lowest index set in PEND & MASK.
- States:
  - IDLE: candidate exists → REQ; load `INTnum`=index+1, `INTin`=1 (registered, next edge).
  - REQ: `INTnum` locked. `int_ack` → SERV: clear that PEND bit, CUR=`INTnum`, `INTin`=0, `INTnum`=0. Masking or W1C of the locked source while in REQ does not withdraw the request.
  - SERV: no new request presented. EOI write → IDLE, CUR=0.
- `int_ack` in IDLE or SERV ignored.
- Simultaneous: edge and W1C on same bit same cycle → bit set. Edge and ack-clear on same bit same cycle → bit stays set (new event). Edge while bit already set → merged (one event).
- Reset mid-operation: returns to reset values next edge; pending events lost.

## Timing
- `src` first sampled high at edge 0 → PEND set at edge 2 → `INTin`=1 and `INTnum` valid after edge 3.
- `int_ack` high at edge k → `INTin`=0 after edge k; CUR valid after k.
- EOI at edge m → IDLE after m; next pending request presented after m+1.
- Read: `rdata` combinational from `reg_addr` while `sel && rd`; reflects state before the current edge.
- Writes take effect at the edge where `sel && wr`.
- Back-to-back: minimum 1 IDLE cycle between EOI and next `INTin`.

## Structure
- Package `int_pkg`: register offsets (PEND/MASK/CUR/EOI), state encoding (IDLE/REQ/SERV), `INTnum` width constant.
- Sub-module `int_sync_edge`: one instance per source (2-flop sync + edge detect, output one-cycle pulse).
- Priority encoder, register file and FSM in `int_ctrl`.

## Test plan
- Reset: assert `rst` 2 cycles → PEND=0, MASK=0xF, CUR=0, `INTin`=0, `INTnum`=0.
- Single event: `src`=0b0001 for 3 cycles → `INTin`=1, `INTnum`=1 after edge 3; ack → CUR=1, PEND=0; EOI → CUR=0.
- Priority: `src` bits 2 and 1 rise same cycle → `INTnum`=2; after ack+EOI → `INTnum`=3 presented.
- Mask: write MASK=0xE, pulse `src[0]` → no `INTin`, PEND=0x1; write MASK=0xF → `INTnum`=1 presented.
- Collisions: W1C PEND bit 1 same cycle as `src[1]` edge → PEND bit 1 = 1; `src[1]` edge on ack cycle → bit 1 re-presented after EOI.
- Reset in SERV: ack, then `rst` → IDLE, CUR=0, pending lost, no `INTin`.
